// File: rtl/sync_fifo_param.sv
`default_nettype none
// ============================================================================
// Module   : sync_fifo_param
// Purpose  : Single-clock FIFO with arbitrary (non power-of-two) depth,
//            programmable almost-full / almost-empty thresholds, occupancy
//            count, sticky overflow / underflow flags and a read_valid
//            qualifier.
// Ports    : clk, reset         - rising-edge clock, synchronous active-high
//                                  reset
//            write_en/write_data - push request and data
//            read_en             - pop request
//            read_data/read_valid- popped data and its qualifier
//            full, empty, almost_full, almost_empty, count
//                                - status decoded from the registered count
//            overflow, underflow - sticky error flags, cleared by reset
// Options  : SYNC_FIFO_FWFT_EN   - when defined, first-word-fall-through read
//                                  (read_data shows the head word, read_en
//                                  acknowledges it); otherwise registered read
//                                  with one cycle of latency.
// Revision : 1.0 - initial release
// ============================================================================
module sync_fifo_param #(
   parameter int DEPTH     = 8,
   parameter int WIDTH     = 8,
   parameter int AF_THRESH = DEPTH - 1,
   parameter int AE_THRESH = 1,
   parameter int CW        = $clog2(DEPTH + 1)
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             write_en,
   input  logic [WIDTH-1:0] write_data,
   input  logic             read_en,
   output logic [WIDTH-1:0] read_data,
   output logic             read_valid,
   output logic             full,
   output logic             empty,
   output logic             almost_full,
   output logic             almost_empty,
   output logic [CW-1:0]    count,
   output logic             overflow,
   output logic             underflow
);

   localparam int            PW        = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam logic [PW-1:0] PTR_LAST  = PW'(DEPTH - 1);
   localparam logic [CW-1:0] CNT_FULL  = CW'(DEPTH);
   localparam logic [CW-1:0] CNT_AF    = CW'(AF_THRESH);
   localparam logic [CW-1:0] CNT_AE    = CW'(AE_THRESH);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [PW-1:0]    wr_ptr;
   logic [PW-1:0]    rd_ptr;
   logic             rd_acc;
   logic             wr_acc;

   // A write into a full FIFO is allowed only when a read frees a slot in
   // the same cycle.
   assign rd_acc = read_en && !empty;
   assign wr_acc = write_en && (!full || rd_acc);

   // Status is decoded purely from the registered count, so no input reaches
   // an output combinationally.
   assign full         = (count == CNT_FULL);
   assign empty        = (count == '0);
   assign almost_full  = (count >= CNT_AF);
   assign almost_empty = (count <= CNT_AE);

   // Pointers, occupancy and sticky error flags
   always_ff @(posedge clk) begin
      if (reset) begin
         wr_ptr    <= '0;
         rd_ptr    <= '0;
         count     <= '0;
         overflow  <= 1'b0;
         underflow <= 1'b0;
      end else begin
         // Wrap by explicit compare so non power-of-two depths work.
         if (wr_acc) begin
            wr_ptr <= (wr_ptr == PTR_LAST) ? '0 : wr_ptr + PW'(1);
         end
         if (rd_acc) begin
            rd_ptr <= (rd_ptr == PTR_LAST) ? '0 : rd_ptr + PW'(1);
         end
         if (wr_acc && !rd_acc) begin
            count <= count + CW'(1);
         end else if (!wr_acc && rd_acc) begin
            count <= count - CW'(1);
         end
         if (write_en && !wr_acc) begin
            overflow <= 1'b1;
         end
         if (read_en && !rd_acc) begin
            underflow <= 1'b1;
         end
      end
   end

   // Storage is not reset; writes in the reset cycle are discarded.
   always_ff @(posedge clk) begin
      if (!reset && wr_acc) begin
         mem[wr_ptr] <= write_data;
      end
   end

`ifdef SYNC_FIFO_FWFT_EN
   // Head word is always presented; read_en merely acknowledges it.
   assign read_data  = mem[rd_ptr];
   assign read_valid = !empty;
`else
   // Registered read: data appears one cycle after an accepted pop and holds
   // its value otherwise.
   always_ff @(posedge clk) begin
      if (reset) begin
         read_data  <= '0;
         read_valid <= 1'b0;
      end else begin
         read_valid <= rd_acc;
         if (rd_acc) begin
            read_data <= mem[rd_ptr];
         end
      end
   end
`endif

endmodule
`default_nettype wire

// File: tb/tb_sync_fifo_param.sv
`default_nettype none
// ============================================================================
// Module   : tb_sync_fifo_param
// Purpose  : Directed self-checking bench for sync_fifo_param. One instance
//            with DEPTH=8 covers fill/drain, thresholds, error flags and
//            reset; a second with DEPTH=6 covers pointer wrap and the
//            write-while-full-with-read case. Read checks adapt to
//            SYNC_FIFO_FWFT_EN.
// Revision : 1.0 - initial release
// ============================================================================
module tb_sync_fifo_param;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   // ---------------- DEPTH = 8 instance ----------------
   logic       rst8 = 1'b1, we8 = 1'b0, re8 = 1'b0;
   logic [7:0] wd8 = '0, rd8;
   logic       rv8, full8, empty8, af8, ae8, of8, uf8;
   logic [3:0] cnt8;

   sync_fifo_param #(.DEPTH(8), .WIDTH(8)) u_dut8 (
      .clk(clk), .reset(rst8), .write_en(we8), .write_data(wd8),
      .read_en(re8), .read_data(rd8), .read_valid(rv8), .full(full8),
      .empty(empty8), .almost_full(af8), .almost_empty(ae8), .count(cnt8),
      .overflow(of8), .underflow(uf8)
   );

   // ---------------- DEPTH = 6 instance ----------------
   logic       rst6 = 1'b1, we6 = 1'b0, re6 = 1'b0;
   logic [7:0] wd6 = '0, rd6;
   logic       rv6, full6, empty6, af6, ae6, of6, uf6;
   logic [2:0] cnt6;

   sync_fifo_param #(.DEPTH(6), .WIDTH(8)) u_dut6 (
      .clk(clk), .reset(rst6), .write_en(we6), .write_data(wd6),
      .read_en(re6), .read_data(rd6), .read_valid(rv6), .full(full6),
      .empty(empty6), .almost_full(af6), .almost_empty(ae6), .count(cnt6),
      .overflow(of6), .underflow(uf6)
   );

   logic [7:0] q6 [$];

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic cyc8(input logic we, input logic [7:0] wd, input logic re);
      we8 = we; wd8 = wd; re8 = re;
      @(posedge clk); #1;
      we8 = 1'b0; re8 = 1'b0;
   endtask

   task automatic pop8(input logic [7:0] exp);
`ifdef SYNC_FIFO_FWFT_EN
      check("pop8_valid", rv8, 1);
      check("pop8_data", rd8, exp);
      cyc8(1'b0, 8'h00, 1'b1);
`else
      cyc8(1'b0, 8'h00, 1'b1);
      check("pop8_valid", rv8, 1);
      check("pop8_data", rd8, exp);
`endif
   endtask

   // Reference-queue driven step for the DEPTH=6 instance.
   task automatic op6(input logic we, input logic [7:0] wd, input logic re);
      logic       racc, wacc;
      logic [7:0] head;
      racc = re && (q6.size() > 0);
      wacc = we && ((q6.size() < 6) || racc);
      head = (q6.size() > 0) ? q6[0] : 8'h00;
`ifdef SYNC_FIFO_FWFT_EN
      if (racc) begin
         check("op6_valid", rv6, 1);
         check("op6_data", rd6, head);
      end
`endif
      we6 = we; wd6 = wd; re6 = re;
      @(posedge clk); #1;
      we6 = 1'b0; re6 = 1'b0;
      if (racc) void'(q6.pop_front());
      if (wacc) q6.push_back(wd);
`ifndef SYNC_FIFO_FWFT_EN
      check("op6_valid", rv6, racc);
      if (racc) check("op6_data", rd6, head);
`endif
      check("op6_count", cnt6, q6.size());
   endtask

   initial begin
      // ---------------- reset state ----------------
      @(posedge clk); #1;
      rst8 = 1'b0; rst6 = 1'b0;
      check("rst_count", cnt8, 0);
      check("rst_empty", empty8, 1);
      check("rst_full", full8, 0);
      check("rst_ae", ae8, 1);
      check("rst_af", af8, 0);
      check("rst_valid", rv8, 0);
      check("rst_of", of8, 0);
      check("rst_uf", uf8, 0);
`ifndef SYNC_FIFO_FWFT_EN
      check("rst_data", rd8, 0);
`endif

      // ---------------- fill 0x01..0x08 ----------------
      for (int i = 1; i <= 8; i++) begin
         cyc8(1'b1, 8'(i), 1'b0);
         check("fill_count", cnt8, i);
         check("fill_empty", empty8, 0);
         check("fill_full", full8, (i == 8));
         check("fill_af", af8, (i >= 7));
         check("fill_ae", ae8, (i <= 1));
`ifdef SYNC_FIFO_FWFT_EN
         check("fwft_head_valid", rv8, 1);
         check("fwft_head_data", rd8, 8'h01);
`else
         check("fill_novalid", rv8, 0);
`endif
      end

      // ---------------- drain 8 ----------------
      for (int i = 1; i <= 8; i++) begin
         pop8(8'(i));
         check("drain_count", cnt8, 8 - i);
         check("drain_empty", empty8, (i == 8));
         check("drain_ae", ae8, ((8 - i) <= 1));
         check("drain_full", full8, 0);
      end
      cyc8(1'b0, 8'h00, 1'b0);
      check("idle_valid", rv8, 0);
`ifndef SYNC_FIFO_FWFT_EN
      check("idle_hold", rd8, 8'h08);
`endif

      // ---------------- underflow ----------------
      cyc8(1'b0, 8'h00, 1'b1);
      check("uf_set", uf8, 1);
      check("uf_valid", rv8, 0);
      check("uf_of", of8, 0);
      check("uf_count", cnt8, 0);

      // ---------------- overflow ----------------
      for (int i = 1; i <= 8; i++) cyc8(1'b1, 8'(8'h30 + i), 1'b0);
      check("of_pre_full", full8, 1);
      check("of_pre_flag", of8, 0);
      cyc8(1'b1, 8'h99, 1'b0);
      check("of_set", of8, 1);
      check("of_count", cnt8, 8);
      for (int i = 1; i <= 5; i++) pop8(8'(8'h30 + i));
      check("sticky_count", cnt8, 3);
      check("sticky_of", of8, 1);
      check("sticky_uf", uf8, 1);

      // ---------------- reset mid-stream with requests ----------------
      rst8 = 1'b1; we8 = 1'b1; wd8 = 8'h77; re8 = 1'b1;
      @(posedge clk); #1;
      rst8 = 1'b0; we8 = 1'b0; re8 = 1'b0;
      check("mrst_count", cnt8, 0);
      check("mrst_empty", empty8, 1);
      check("mrst_of", of8, 0);
      check("mrst_uf", uf8, 0);
      check("mrst_valid", rv8, 0);

      // ---------------- empty: read+write together ----------------
      cyc8(1'b1, 8'h5A, 1'b1);
      check("ew_uf", uf8, 1);
      check("ew_count", cnt8, 1);
      check("ew_of", of8, 0);
`ifdef SYNC_FIFO_FWFT_EN
      check("ew_valid", rv8, 1);
`else
      check("ew_valid", rv8, 0);
      check("ew_nobypass", rd8, 0);
`endif
      pop8(8'h5A);
      check("ew_empty", empty8, 1);

      // ---------------- DEPTH=6 wrap ----------------
      for (int i = 0; i < 4; i++) op6(1'b1, 8'(8'h10 + i), 1'b0);
      for (int i = 4; i < 20; i++) op6(1'b1, 8'(8'h10 + i), 1'b1);
      while (q6.size() > 0) op6(1'b0, 8'h00, 1'b1);
      check("wrap_empty", empty6, 1);
      check("wrap_of", of6, 0);
      check("wrap_uf", uf6, 0);

      // ---------------- DEPTH=6 full with simultaneous read/write ----------------
      for (int i = 0; i < 6; i++) op6(1'b1, 8'(8'h40 + i), 1'b0);
      check("f6_full", full6, 1);
      check("f6_af", af6, 1);
      op6(1'b1, 8'hAA, 1'b1);
      check("f6_rw_count", cnt6, 6);
      check("f6_rw_of", of6, 0);
      for (int i = 0; i < 5; i++) op6(1'b0, 8'h00, 1'b1);
      check("f6_last_count", cnt6, 1);
`ifdef SYNC_FIFO_FWFT_EN
      check("f6_aa_valid", rv6, 1);
      check("f6_aa_data", rd6, 8'hAA);
      cyc8(1'b0, 8'h00, 1'b0);
      re6 = 1'b1;
      @(posedge clk); #1;
      re6 = 1'b0;
`else
      re6 = 1'b1;
      @(posedge clk); #1;
      re6 = 1'b0;
      check("f6_aa_valid", rv6, 1);
      check("f6_aa_data", rd6, 8'hAA);
`endif
      check("f6_empty", empty6, 1);
      check("f6_uf", uf6, 0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
`default_nettype wire
